vx_serial_divider_et: RTL and testbench

- Multi-lane iterative integer divider with early termination, for the next-generation muldiv unit's divide path.
- Single outstanding operation.
- Supports signed/unsigned DIV/REM and RV64 W-mode; handles RISC-V div-by-zero and overflow in-band.
- Skips leading-zero iterations so short operands finish early; carries an opaque tag for commit.

---
 rtl/vx_serial_divider_et_pkg.sv | 28 ++
 rtl/vx_div_lane_step.sv | 28 ++
 rtl/vx_serial_divider_et.sv | 185 ++++++++++++++++++
 tb/tb_vx_serial_divider_et.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_serial_divider_et_pkg.sv
// Shared types and helpers for the serial divider.
// State encoding, counter width and leading-zero count.
package vx_serial_divider_et_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIXUP,
    DONE
  } state_e;

  localparam int MAX_WIDTH = 64;
  localparam int ITER_CNT_W = $clog2(MAX_WIDTH + 1);

  // leading zeros of a left-aligned 64-bit value, 64 when zero
  function automatic logic [ITER_CNT_W-1:0] clz64(
    input logic [63:0] v
  );
    logic [ITER_CNT_W-1:0] n;
    n = ITER_CNT_W'(64);
    for (int i = 0; i < 64; i++) begin
      if (v[i]) n = ITER_CNT_W'(63 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/vx_div_lane_step.sv
// One restoring radix-2 divide step for a single lane.
// Remainder and dividend/quotient shift register in, updated pair out.
module vx_div_lane_step
  import vx_serial_divider_et_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] den,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;

  // shift in next dividend bit, subtract when it fits
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    ge      = shifted >= {1'b0, den};
    diff    = shifted - {1'b0, den};
    rem_out = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/vx_serial_divider_et.sv
// Multi-lane iterative divider with early termination.
// Signed/unsigned DIV/REM, W-mode, RISC-V corner cases.
module vx_serial_divider_et
  import vx_serial_divider_et_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic                   is_signed,
  input  logic                   is_rem,
  input  logic                   is_w,
  input  logic [LANES-1:0]       tmask_in,
  input  logic [LANES*WIDTH-1:0] numer,
  input  logic [LANES*WIDTH-1:0] denom,
  input  logic [TAG_WIDTH-1:0]   tag_in,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic [LANES*WIDTH-1:0] result,
  output logic [LANES-1:0]       tmask_out,
  output logic [TAG_WIDTH-1:0]   tag_out,
  output logic                   busy
);

  localparam int CW = ITER_CNT_W;

  state_e                 state, state_nx;
  logic [CW-1:0]          cnt, iters, lz_min, ew;
  logic                   sgn_q, rem_q, w_q;
  logic [LANES-1:0]       tmask_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [LANES*WIDTH-1:0] numer_q, denom_q;
  logic [LANES*WIDTH-1:0] result_q, fix;
  logic [WIDTH-1:0]       rem_r    [LANES];
  logic [WIDTH-1:0]       quo_r    [LANES];
  logic [WIDTH-1:0]       rem_nx   [LANES];
  logic [WIDTH-1:0]       quo_nx   [LANES];
  logic [WIDTH-1:0]       n_t      [LANES];
  logic [WIDTH-1:0]       d_t      [LANES];
  logic [WIDTH-1:0]       n_mag    [LANES];
  logic [WIDTH-1:0]       d_mag    [LANES];
  logic [WIDTH-1:0]       quo_init [LANES];
  logic [LANES-1:0]       n_neg, d_neg;
  logic [WIDTH-1:0]       lo_mask, min_v;
  logic [6:0]             sh;
  logic                   w_mode, fire;

  assign ready_in  = (state == IDLE);
  assign fire      = valid_in && ready_in;
  assign valid_out = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = result_q;
  assign tmask_out = tmask_q;
  assign tag_out   = tag_q;

  assign w_mode  = (WIDTH > 32) && w_q;
  assign lo_mask = w_mode ? WIDTH'(32'hFFFF_FFFF) : '1;
  assign min_v   = lo_mask ^ (lo_mask >> 1);
  assign ew      = w_mode ? CW'(32) : CW'(WIDTH);
  assign sh      = w_mode ? 7'd32 : 7'(64 - WIDTH);

  // truncate operands to the effective width and take magnitudes
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      n_t[i]   = numer_q[i*WIDTH +: WIDTH] & lo_mask;
      d_t[i]   = denom_q[i*WIDTH +: WIDTH] & lo_mask;
      n_neg[i] = sgn_q && ((n_t[i] & min_v) != '0);
      d_neg[i] = sgn_q && ((d_t[i] & min_v) != '0);
      n_mag[i] = n_neg[i] ? ((-n_t[i]) & lo_mask) : n_t[i];
      d_mag[i] = d_neg[i] ? ((-d_t[i]) & lo_mask) : d_t[i];
    end
  end

  // iteration count from the widest active numerator
  always_comb begin
    logic [CW-1:0] lz_l;
    lz_min = ew;
    for (int i = 0; i < LANES; i++) begin
      lz_l = clz64(64'(n_mag[i]) << sh);
      if (tmask_q[i] && lz_l < lz_min) lz_min = lz_l;
    end
    iters = ew - lz_min;
    for (int i = 0; i < LANES; i++) begin
      quo_init[i] = n_mag[i] << (CW'(WIDTH) - iters);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vx_div_lane_step #(.WIDTH(WIDTH)) u_step (
      .rem_in (rem_r[g]),
      .quo_in (quo_r[g]),
      .den    (d_mag[g]),
      .rem_out(rem_nx[g]),
      .quo_out(quo_nx[g])
    );
  end

  // sign restore, div-by-zero and overflow, W-mode extension
  always_comb begin
    logic [WIDTH-1:0] q_v, r_v, sel;
    fix = '0;
    for (int i = 0; i < LANES; i++) begin
      q_v = (n_neg[i] ^ d_neg[i]) ? -quo_r[i] : quo_r[i];
      r_v = n_neg[i] ? -rem_r[i] : rem_r[i];
      if (d_t[i] == '0) begin
        q_v = '1;
        r_v = n_t[i];
      end else if (sgn_q && n_t[i] == min_v && d_t[i] == lo_mask) begin
        q_v = min_v;
        r_v = '0;
      end
      sel = rem_q ? r_v : q_v;
      if (w_mode) sel = WIDTH'($signed(sel[31:0]));
      if (tmask_q[i]) fix[i*WIDTH +: WIDTH] = sel;
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (fire) state_nx = PREP;
      PREP:    state_nx = (iters == '0) ? FIXUP : ITER;
      ITER:    if (cnt == CW'(1)) state_nx = FIXUP;
      FIXUP:   state_nx = DONE;
      DONE:    if (ready_out) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // request capture, iteration datapath and result register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      sgn_q    <= 1'b0;
      rem_q    <= 1'b0;
      w_q      <= 1'b0;
      tmask_q  <= '0;
      tag_q    <= '0;
      numer_q  <= '0;
      denom_q  <= '0;
      result_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        rem_r[i] <= '0;
        quo_r[i] <= '0;
      end
    end else begin
      if (fire) begin
        sgn_q   <= is_signed;
        rem_q   <= is_rem;
        w_q     <= is_w;
        tmask_q <= tmask_in;
        tag_q   <= tag_in;
        numer_q <= numer;
        denom_q <= denom;
      end
      if (state == PREP) begin
        cnt <= iters;
        for (int i = 0; i < LANES; i++) begin
          rem_r[i] <= '0;
          quo_r[i] <= quo_init[i];
        end
      end
      if (state == ITER) begin
        cnt <= cnt - CW'(1);
        for (int i = 0; i < LANES; i++) begin
          rem_r[i] <= rem_nx[i];
          quo_r[i] <= quo_nx[i];
        end
      end
      if (state == FIXUP) result_q <= fix;
    end
  end

endmodule

// File: tb/tb_vx_serial_divider_et.sv
// Directed checks for vx_serial_divider_et.
// 4x32 instance plus a 1x64 instance for W-mode.
module tb_vx_serial_divider_et;

  typedef struct {
    logic         sgn;
    logic         rem;
    logic [3:0]   tm;
    logic [127:0] n;
    logic [127:0] d;
    logic [127:0] q;
    int           edges;
  } vec_t;

  typedef struct {
    logic        sgn;
    logic        rem;
    logic        w;
    logic [63:0] n;
    logic [63:0] d;
    logic [63:0] q;
    int          edges;
  } v64_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         valid_in = 1'b0;
  logic         ready_in;
  logic         is_signed = 1'b0;
  logic         is_rem = 1'b0;
  logic         is_w = 1'b0;
  logic [3:0]   tmask_in = '0;
  logic [127:0] numer = '0;
  logic [127:0] denom = '0;
  logic [7:0]   tag_in = '0;
  logic         valid_out;
  logic         ready_out = 1'b0;
  logic [127:0] result;
  logic [3:0]   tmask_out;
  logic [7:0]   tag_out;
  logic         busy;

  logic         v64_in = 1'b0;
  logic         r64_in;
  logic         sgn64 = 1'b0;
  logic         rem64 = 1'b0;
  logic         w64 = 1'b0;
  logic [0:0]   tm64 = 1'b1;
  logic [63:0]  n64 = '0;
  logic [63:0]  d64 = '0;
  logic [7:0]   tag64 = '0;
  logic         vo64;
  logic         ro64 = 1'b0;
  logic [63:0]  res64;
  logic [0:0]   tmo64;
  logic [7:0]   tago64;
  logic         busy64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_serial_divider_et #(.LANES(4), .WIDTH(32), .TAG_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .valid_in(valid_in), .ready_in(ready_in),
    .is_signed(is_signed), .is_rem(is_rem), .is_w(is_w),
    .tmask_in(tmask_in), .numer(numer), .denom(denom),
    .tag_in(tag_in), .valid_out(valid_out), .ready_out(ready_out),
    .result(result), .tmask_out(tmask_out), .tag_out(tag_out),
    .busy(busy)
  );

  vx_serial_divider_et #(.LANES(1), .WIDTH(64), .TAG_WIDTH(8)) dut64 (
    .clk(clk), .reset_n(reset_n),
    .valid_in(v64_in), .ready_in(r64_in),
    .is_signed(sgn64), .is_rem(rem64), .is_w(w64),
    .tmask_in(tm64), .numer(n64), .denom(d64),
    .tag_in(tag64), .valid_out(vo64), .ready_out(ro64),
    .result(res64), .tmask_out(tmo64), .tag_out(tago64),
    .busy(busy64)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic op32(input vec_t v, input logic [7:0] tg,
                      output int edges, output logic [127:0] res,
                      output logic [7:0] tgo, output logic [3:0] tmo);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!ready_in && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_in_idle", 64'(ready_in), 64'(1));
    is_signed = v.sgn;
    is_rem    = v.rem;
    is_w      = 1'b0;
    tmask_in  = v.tm;
    numer     = v.n;
    denom     = v.d;
    tag_in    = tg;
    valid_in  = 1'b1;
    @(posedge clk);
    #1;
    valid_in  = 1'b0;
    numer     = {$urandom, $urandom, $urandom, $urandom};
    denom     = {$urandom, $urandom, $urandom, $urandom};
    tag_in    = 8'($urandom);
    tmask_in  = 4'($urandom);
    is_signed = ~is_signed;
    is_rem    = ~is_rem;
    edges = 0;
    while (!valid_out && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    res = result;
    tgo = tag_out;
    tmo = tmask_out;
    ready_out = 1'b1;
    @(posedge clk);
    #1;
    ready_out = 1'b0;
  endtask

  task automatic op64(input v64_t v, output int edges,
                      output logic [63:0] res);
    @(negedge clk);
    sgn64  = v.sgn;
    rem64  = v.rem;
    w64    = v.w;
    n64    = v.n;
    d64    = v.d;
    tag64  = 8'h5A;
    v64_in = 1'b1;
    @(posedge clk);
    #1;
    v64_in = 1'b0;
    n64    = {$urandom, $urandom};
    d64    = {$urandom, $urandom};
    edges = 0;
    while (!vo64 && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    res = res64;
    ro64 = 1'b1;
    @(posedge clk);
    #1;
    ro64 = 1'b0;
  endtask

  vec_t vecs[14];
  v64_t v64s[5];

  initial begin
    int           e;
    logic [127:0] r;
    logic [63:0]  r64;
    logic [7:0]   tg;
    logic [3:0]   tm;

    vecs[0]  = '{1'b0, 1'b0, 4'hF, {4{32'd100}}, {4{32'd7}},
                 {4{32'd14}}, 9};
    vecs[1]  = '{1'b0, 1'b1, 4'hF, {4{32'd100}}, {4{32'd7}},
                 {4{32'd2}}, 9};
    vecs[2]  = '{1'b1, 1'b0, 4'hF, {4{32'hFFFFFFF9}}, {4{32'd2}},
                 {4{32'hFFFFFFFD}}, 5};
    vecs[3]  = '{1'b1, 1'b1, 4'hF, {4{32'hFFFFFFF9}}, {4{32'd2}},
                 {4{32'hFFFFFFFF}}, 5};
    vecs[4]  = '{1'b1, 1'b0, 4'hF, {4{32'h80000000}},
                 {4{32'hFFFFFFFF}}, {4{32'h80000000}}, 34};
    vecs[5]  = '{1'b1, 1'b1, 4'hF, {4{32'h80000000}},
                 {4{32'hFFFFFFFF}}, {4{32'h0}}, 34};
    vecs[6]  = '{1'b0, 1'b0, 4'hF,
                 {32'd10, 32'h1234, 32'd10, 32'd10},
                 {32'd3, 32'd0, 32'd3, 32'd3},
                 {32'd3, 32'hFFFFFFFF, 32'd3, 32'd3}, 15};
    vecs[7]  = '{1'b0, 1'b1, 4'hF,
                 {32'd10, 32'h1234, 32'd10, 32'd10},
                 {32'd3, 32'd0, 32'd3, 32'd3},
                 {32'd1, 32'h1234, 32'd1, 32'd1}, 15};
    vecs[8]  = '{1'b0, 1'b0, 4'b0101,
                 {32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd5},
                 {4{32'd1}},
                 {32'd0, 32'd5, 32'd0, 32'd5}, 5};
    vecs[9]  = '{1'b0, 1'b0, 4'h0, {4{32'hDEADBEEF}}, {4{32'd0}},
                 {4{32'd0}}, 2};
    vecs[10] = '{1'b0, 1'b0, 4'hF, {4{32'd0}},
                 {32'd5, 32'd5, 32'd0, 32'd5},
                 {32'd0, 32'd0, 32'hFFFFFFFF, 32'd0}, 2};
    vecs[11] = '{1'b0, 1'b0, 4'hF,
                 {32'd123456, 32'd7, 32'hFFFFFFFF, 32'd1000},
                 {32'd789, 32'd9, 32'd1, 32'd10},
                 {32'd156, 32'd0, 32'hFFFFFFFF, 32'd100}, 34};
    vecs[12] = '{1'b1, 1'b0, 4'hF,
                 {32'hFFFFFFFB, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd7},
                 {32'd0, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE},
                 {32'hFFFFFFFF, 32'hFFFFFFF2, 32'd3, 32'hFFFFFFFD}, 9};
    vecs[13] = '{1'b1, 1'b1, 4'hF,
                 {32'hFFFFFFFB, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd7},
                 {32'd0, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE},
                 {32'hFFFFFFFB, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1}, 9};

    v64s[0] = '{1'b1, 1'b0, 1'b1, 64'hDEADBEEF_FFFFFFF8,
                64'h12345678_00000002, 64'hFFFFFFFF_FFFFFFFC, 6};
    v64s[1] = '{1'b1, 1'b1, 1'b1, 64'hCAFE0000_FFFFFFF8,
                64'h00000001_00000003, 64'hFFFFFFFF_FFFFFFFE, 6};
    v64s[2] = '{1'b0, 1'b0, 1'b1, 64'hABCD0000_00000064,
                64'h77770000_00000007, 64'd14, 9};
    v64s[3] = '{1'b0, 1'b0, 1'b0, 64'h00000001_00000000,
                64'd2, 64'h00000000_80000000, 35};
    v64s[4] = '{1'b1, 1'b1, 1'b1, 64'h12340000_80000005,
                64'h55550000_00000000, 64'hFFFFFFFF_80000005, 33};

    #12;
    chk("rst_valid_out", 64'(valid_out), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready_in", 64'(ready_in), 64'(1));
    chk("rst_result", result[63:0], 64'h0);
    chk("rst_tag", 64'(tag_out), 64'h0);
    chk("rst_tmask", 64'(tmask_out), 64'h0);
    chk("rst_valid_out64", 64'(vo64), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      op32(vecs[i], 8'(8'h40 + i), e, r, tg, tm);
      chk($sformatf("v%0d_edges", i), 64'(e), 64'(vecs[i].edges));
      for (int l = 0; l < 4; l++) begin
        chk($sformatf("v%0d_lane%0d", i, l), 64'(r[l*32 +: 32]),
            64'(vecs[i].q[l*32 +: 32]));
      end
      chk($sformatf("v%0d_tag", i), 64'(tg), 64'(8'h40 + i));
      chk($sformatf("v%0d_tmask", i), 64'(tm), 64'(vecs[i].tm));
    end

    for (int i = 0; i < 5; i++) begin
      op64(v64s[i], e, r64);
      chk($sformatf("w%0d_edges", i), 64'(e), 64'(v64s[i].edges));
      chk($sformatf("w%0d_result", i), r64, v64s[i].q);
    end
    chk("w_tag", 64'(tago64), 64'h5A);
    chk("w_tmask", 64'(tmo64), 64'h1);

    // stall in DONE with a second request pending
    @(negedge clk);
    is_signed = 1'b0;
    is_rem    = 1'b0;
    tmask_in  = vecs[8].tm;
    numer     = vecs[8].n;
    denom     = vecs[8].d;
    tag_in    = 8'hA5;
    valid_in  = 1'b1;
    @(posedge clk);
    #1;
    numer  = {4{32'd77}};
    denom  = {4{32'd3}};
    tag_in = 8'h11;
    e = 0;
    while (!valid_out && e < 100) begin
      @(posedge clk);
      #1;
      e++;
    end
    chk("stall_edges", 64'(e), 64'(5));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_valid", k), 64'(valid_out), 64'(1));
      chk($sformatf("stall%0d_ready_in", k), 64'(ready_in), 64'(0));
      chk($sformatf("stall%0d_result", k), result[63:0],
          vecs[8].q[63:0]);
      chk($sformatf("stall%0d_tag", k), 64'(tag_out), 64'hA5);
    end
    @(negedge clk);
    valid_in  = 1'b0;
    ready_out = 1'b1;
    @(posedge clk);
    #1;
    ready_out = 1'b0;
    chk("stall_release_valid", 64'(valid_out), 64'(0));
    chk("stall_release_busy", 64'(busy), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("stall_no_second_accept", 64'(busy), 64'(0));

    // ready_out held high before the result exists
    @(negedge clk);
    ready_out = 1'b1;
    is_signed = 1'b0;
    is_rem    = 1'b0;
    tmask_in  = 4'hF;
    numer     = vecs[0].n;
    denom     = vecs[0].d;
    tag_in    = 8'h33;
    valid_in  = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    e = 0;
    while (!valid_out && e < 100) begin
      @(posedge clk);
      #1;
      e++;
    end
    chk("early_ready_edges", 64'(e), 64'(9));
    chk("early_ready_result", result[127:64], vecs[0].q[127:64]);
    @(posedge clk);
    #1;
    ready_out = 1'b0;
    chk("early_ready_consumed", 64'(valid_out), 64'(0));

    // asynchronous reset in the middle of iteration
    @(negedge clk);
    is_signed = 1'b0;
    tmask_in  = 4'hF;
    numer     = {4{32'h80000000}};
    denom     = {4{32'd1}};
    tag_in    = 8'h77;
    valid_in  = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid_out", 64'(valid_out), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_ready_in", 64'(ready_in), 64'(1));
    chk("arst_result", result[63:0], 64'h0);
    chk("arst_tag", 64'(tag_out), 64'h0);
    #1;
    reset_n = 1'b1;
    op32(vecs[1], 8'h99, e, r, tg, tm);
    chk("post_rst_edges", 64'(e), 64'(9));
    chk("post_rst_lane0", 64'(r[31:0]), 64'(32'd2));
    chk("post_rst_lane3", 64'(r[127:96]), 64'(32'd2));
    chk("post_rst_tag", 64'(tg), 64'h99);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
